// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: FSM state encoding, default datapath width and
// the ALU opcodes that decode turns into ctrl_mult/ctrl_div.
package pipeline_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic [4:0] ALU_MULT = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  function automatic logic is_muldiv(input logic [4:0] alu_op);
    return (alu_op == ALU_MULT) || (alu_op == ALU_DIV);
  endfunction

endpackage

// File: rtl/multdiv_iter_if.sv
// Start/operand/result bundle between the execute stage and the iterative
// multiply/divide unit.
interface multdiv_iter_if #(
  parameter int WIDTH = 32
);
  logic             ctrl_mult;
  logic             ctrl_div;
  logic             flush;
  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             ready;
  logic             busy;

  modport master (
    output ctrl_mult, ctrl_div, flush, data_a, data_b,
    input  data_result, data_exception, ready, busy
  );

  modport slave (
    input  ctrl_mult, ctrl_div, flush, data_a, data_b,
    output data_result, data_exception, ready, busy
  );
endinterface

// File: rtl/multdiv_iter_div_step.sv
// One non-restoring divide iteration on magnitudes: shift in the next dividend
// bit, add or subtract the divisor by remainder sign, emit the quotient bit.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH+1:0] rem,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH+1:0] rem_next,
  output logic             q_bit
);
  logic [WIDTH+1:0] shifted;

  // Remainder stays in [-d, d), so WIDTH+1 bits hold it before the shift.
  assign shifted  = {rem[WIDTH:0], dividend_bit};
  assign rem_next = rem[WIDTH+1] ? shifted + {2'b00, divisor}
                                 : shifted - {2'b00, divisor};
  assign q_bit    = ~rem_next[WIDTH+1];
endmodule

// File: rtl/multdiv_iter.sv
// Iterative signed multiply / non-restoring divide: 32 iterations per op on
// operand magnitudes, sign and exception applied on the final iteration.
module multdiv_iter
  import pipeline_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 6
) (
  input logic           clk,
  input logic           clrn,
  multdiv_iter_if.slave bus
);

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic               op_div, neg, b_zero;
  logic [WIDTH-1:0]   opnd, lo, lo_nx;
  logic [WIDTH+1:0]   acc, acc_nx, drem_nx;
  logic               dq_bit;
  logic [WIDTH:0]     msum;
  logic [2*WIDTH-1:0] prod, sprod;
  logic [WIDTH-1:0]   quo, squo, res_nx, res_q;
  logic               exc_nx, exc_q;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               start, last;

  assign start = bus.ctrl_mult ^ bus.ctrl_div;
  assign last  = (cnt == CNT_W'(WIDTH-1));
  assign mag_a = bus.data_a[WIDTH-1] ? -bus.data_a : bus.data_a;
  assign mag_b = bus.data_b[WIDTH-1] ? -bus.data_b : bus.data_b;

  assign bus.busy           = (state == ST_RUN);
  assign bus.ready          = (state == ST_DONE);
  assign bus.data_result    = res_q;
  assign bus.data_exception = exc_q;

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem          (acc),
    .dividend_bit (lo[WIDTH-1]),
    .divisor      (opnd),
    .rem_next     (drem_nx),
    .q_bit        (dq_bit)
  );

  always_comb begin
    state_nx = state;
    if (bus.flush) begin
      state_nx = ST_IDLE;
    end else if (start) begin
      state_nx = ST_RUN;
    end else begin
      case (state)
        ST_RUN:  if (last) state_nx = ST_DONE;
        ST_DONE: state_nx = ST_IDLE;
        default: state_nx = state;
      endcase
    end
  end

  // The final iteration's next-state value is signed and checked in the same
  // cycle, so the result lands exactly on the DONE transition edge.
  always_comb begin
    msum = lo[0] ? ({1'b0, acc[WIDTH-1:0]} + {1'b0, opnd}) : {1'b0, acc[WIDTH-1:0]};
    if (op_div) begin
      acc_nx = drem_nx;
      lo_nx  = {lo[WIDTH-2:0], dq_bit};
    end else begin
      acc_nx = {2'b00, msum[WIDTH:1]};
      lo_nx  = {msum[0], lo[WIDTH-1:1]};
    end
    prod  = {acc_nx[WIDTH-1:0], lo_nx};
    sprod = neg ? -prod : prod;
    quo   = lo_nx;
    squo  = neg ? -quo : quo;
    if (op_div) begin
      res_nx = b_zero ? '0 : squo;
      exc_nx = b_zero | (~neg & quo[WIDTH-1]);
    end else begin
      res_nx = sprod[WIDTH-1:0];
      exc_nx = (sprod[2*WIDTH-1:WIDTH] != {WIDTH{sprod[WIDTH-1]}});
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      op_div <= 1'b0;
      neg    <= 1'b0;
      b_zero <= 1'b0;
      opnd   <= '0;
      lo     <= '0;
      acc    <= '0;
      res_q  <= '0;
      exc_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if (!bus.flush && start) begin
        op_div <= bus.ctrl_div;
        neg    <= bus.data_a[WIDTH-1] ^ bus.data_b[WIDTH-1];
        b_zero <= (bus.data_b == '0);
        opnd   <= bus.ctrl_div ? mag_b : mag_a;
        lo     <= bus.ctrl_div ? mag_a : mag_b;
        acc    <= '0;
        cnt    <= '0;
      end else if (!bus.flush && state == ST_RUN) begin
        acc <= acc_nx;
        lo  <= lo_nx;
        if (last) begin
          res_q <= res_nx;
          exc_q <= exc_nx;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_multdiv_iter.sv
// Directed and random checks of multdiv_iter against a plain-arithmetic model.
module tb_multdiv_iter;
  localparam int W = 32;
  localparam logic [W-1:0] MIN_V = 32'h8000_0000;

  logic clk = 1'b0;
  logic clrn;
  always #5 clk = ~clk;

  multdiv_iter_if #(.WIDTH(W)) bus ();
  multdiv_iter #(.WIDTH(W), .CNT_W(6)) dut (.clk(clk), .clrn(clrn), .bus(bus));

  int n_checks = 0;
  int n_fails  = 0;
  logic [W-1:0] exp_res;
  logic         exp_exc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic is_div, input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    int q;
    if (!is_div) begin
      p = longint'($signed(a)) * longint'($signed(b));
      exp_res = p[31:0];
      exp_exc = (p != longint'($signed(p[31:0])));
    end else if (b == '0) begin
      exp_res = '0;
      exp_exc = 1'b1;
    end else if (a == MIN_V && b == '1) begin
      exp_res = MIN_V;
      exp_exc = 1'b1;
    end else begin
      q = $signed(a) / $signed(b);
      exp_res = q;
      exp_exc = 1'b0;
    end
  endtask

  task automatic launch(input logic is_div, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.ctrl_mult = ~is_div;
    bus.ctrl_div  = is_div;
    bus.data_a    = a;
    bus.data_b    = b;
    @(posedge clk);
    #1;
    bus.ctrl_mult = 1'b0;
    bus.ctrl_div  = 1'b0;
    bus.data_a    = $urandom;
    bus.data_b    = $urandom;
  endtask

  // Called 1 time unit after the start edge E0; follows 34 further edges.
  task automatic observe(input string tag);
    int ready_at = -1;
    int ready_cnt = 0;
    int busy_cnt = 0;
    if (bus.busy) busy_cnt++;
    for (int k = 1; k <= 34; k++) begin
      @(posedge clk);
      #1;
      if (bus.busy) busy_cnt++;
      if (bus.ready) begin
        ready_cnt++;
        if (ready_at < 0) ready_at = k;
      end
    end
    check({tag, "_ready_edge"}, 64'(ready_at), 64'd32);
    check({tag, "_ready_cnt"}, 64'(ready_cnt), 64'd1);
    check({tag, "_busy_cnt"}, 64'(busy_cnt), 64'd32);
    check({tag, "_result"}, 64'(bus.data_result), 64'(exp_res));
    check({tag, "_exc"}, 64'(bus.data_exception), 64'(exp_exc));
  endtask

  task automatic run(input string tag, input logic is_div, input logic [W-1:0] a, input logic [W-1:0] b);
    model(is_div, a, b);
    launch(is_div, a, b);
    observe(tag);
  endtask

  task automatic watch(input int n, output int rdy, output int bsy);
    rdy = 0;
    bsy = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (bus.ready) rdy++;
      if (bus.busy) bsy++;
    end
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return MIN_V;
      2:       return '1;
      3:       return W'($urandom_range(1, 20));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    logic [W-1:0] prev_res, ra, rb;
    logic         prev_exc, rdiv;
    int           rdy, bsy;

    clrn = 1'b0;
    bus.ctrl_mult = 1'b0;
    bus.ctrl_div  = 1'b0;
    bus.flush     = 1'b0;
    bus.data_a    = '0;
    bus.data_b    = '0;
    #12;
    check("rst_result", 64'(bus.data_result), 64'd0);
    check("rst_exc", 64'(bus.data_exception), 64'd0);
    check("rst_ready", 64'(bus.ready), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    clrn = 1'b1;

    run("mul_7x-3", 1'b0, 32'd7, -32'sd3);
    run("mul_ovf", 1'b0, 32'h0001_0000, 32'h0001_0000);
    run("mul_m1xm1", 1'b0, '1, '1);
    run("div_-7/2", 1'b1, -32'sd7, 32'd2);
    run("div_by0", 1'b1, 32'd5, 32'd0);
    run("div_min/-1", 1'b1, MIN_V, '1);
    run("div_min/1", 1'b1, MIN_V, 32'd1);
    run("mul_minx1", 1'b0, MIN_V, 32'd1);

    // Restart while busy: only the second op completes.
    model(1'b1, 32'd1000, -32'sd9);
    launch(1'b0, 32'd5, 32'd6);
    repeat (5) @(posedge clk);
    launch(1'b1, 32'd1000, -32'sd9);
    observe("abort_restart");

    // Start in the DONE cycle: first op still reports, second begins.
    model(1'b0, -32'sd12345, 32'd678);
    launch(1'b0, -32'sd12345, 32'd678);
    repeat (31) @(posedge clk);
    #1;
    check("done_start_busy_pre", 64'(bus.busy), 64'd1);
    @(posedge clk);
    #1;
    check("done_start_ready", 64'(bus.ready), 64'd1);
    check("done_start_res", 64'(bus.data_result), 64'(exp_res));
    model(1'b1, 32'd99999, -32'sd77);
    launch(1'b1, 32'd99999, -32'sd77);
    observe("done_start_second");

    // Flush at iteration 10 of mult 3x4.
    prev_res = exp_res;
    prev_exc = exp_exc;
    launch(1'b0, 32'd3, 32'd4);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    check("flush_busy", 64'(bus.busy), 64'd0);
    check("flush_ready", 64'(bus.ready), 64'd0);
    watch(40, rdy, bsy);
    check("flush_no_ready", 64'(rdy), 64'd0);
    check("flush_res_kept", 64'(bus.data_result), 64'(prev_res));
    check("flush_exc_kept", 64'(bus.data_exception), 64'(prev_exc));

    // Flush together with a start: flush wins.
    @(negedge clk);
    bus.flush     = 1'b1;
    bus.ctrl_mult = 1'b1;
    bus.data_a    = 32'd9;
    bus.data_b    = 32'd9;
    @(posedge clk);
    #1;
    bus.flush     = 1'b0;
    bus.ctrl_mult = 1'b0;
    watch(36, rdy, bsy);
    check("flush_start_busy", 64'(bsy), 64'd0);
    check("flush_start_ready", 64'(rdy), 64'd0);

    run("div_100/7", 1'b1, 32'd100, 32'd7);

    // Asynchronous reset at iteration 20.
    launch(1'b0, $urandom, $urandom);
    repeat (19) @(posedge clk);
    @(negedge clk);
    #2;
    clrn = 1'b0;
    #1;
    check("arst_result", 64'(bus.data_result), 64'd0);
    check("arst_exc", 64'(bus.data_exception), 64'd0);
    check("arst_ready", 64'(bus.ready), 64'd0);
    check("arst_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    clrn = 1'b1;
    watch(40, rdy, bsy);
    check("arst_no_ready", 64'(rdy), 64'd0);
    check("arst_no_busy", 64'(bsy), 64'd0);

    // Both start strobes high: ignored.
    @(negedge clk);
    bus.ctrl_mult = 1'b1;
    bus.ctrl_div  = 1'b1;
    bus.data_a    = 32'd6;
    bus.data_b    = 32'd0;
    @(posedge clk);
    #1;
    bus.ctrl_mult = 1'b0;
    bus.ctrl_div  = 1'b0;
    watch(36, rdy, bsy);
    check("both_busy", 64'(bsy), 64'd0);
    check("both_ready", 64'(rdy), 64'd0);
    check("both_exc", 64'(bus.data_exception), 64'd0);
    check("both_result", 64'(bus.data_result), 64'd0);

    for (int i = 0; i < 24; i++) begin
      rdiv = 1'($urandom_range(0, 1));
      ra   = pick_operand();
      rb   = pick_operand();
      run(rdiv ? "rand_div" : "rand_mul", rdiv, ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
